fp_norm_round_single: RTL and testbench
=======================================

# fp_norm_round_single

Post-add normalize/round stage for the single-precision add/sub datapath. Takes the raw sign, exponent and 28-bit unnormalized mantissa produced by the add/sub core, then performs leading-zero normalization, round-to-nearest-even and IEEE-754 packing in a 2-stage valid/ready pipeline. It sits directly downstream of `fsub_single`/`fadd_single` and upstream of the register file or result bus. Special operands (NaN/Inf/zero inputs) are resolved upstream and passed through on a bypass.

## Interface
- No parameters; widths fixed to IEEE-754 binary32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_sign` in 1: result sign.
- `in_exp` in 8: biased exponent of the larger operand, range 1..254.
- `in_mant` in 28: `[27]` carry (2^1), `[26]` hidden (2^0), `[25:3]` fraction, `[2]` guard, `[1]` round, `[0]` sticky.
- `in_special` in 1: bypass; emit `in_special_val` unchanged.
- `in_special_val` in 32: pre-resolved special result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: packed binary32 result.
- `out_flags` out 3: `{overflow, underflow, inexact}`; present only with `FP_NR_FLAGS_EN`.

## Operation
- **S1 (normalize):**
  - If `in_mant[27]`: shift right 1, new sticky = S | R, exp+1.
  - Else: lzc = leading zeros from bit 26; shift left lzc with zero fill, exp−lzc.
  - Exponent is carried as 10-bit signed.
  - `in_mant==0`: zero flag set; result is +0 regardless of `in_sign`.
- **S2 (round/pack):**
  - round_up = G & (R | S | LSB).
  - Mantissa carry-out after rounding: shift right 1, exp+1.
  - exp ≥ 255: result ±Inf (0x7F800000 | sign), overflow=1, inexact=1.
  - exp ≤ 0: flush to signed zero, underflow=1, inexact=1. No subnormal outputs.
  - Otherwise pack `{sign, exp[7:0], frac[22:0]}`; inexact = G | R | S.
  - Special beats skip all arithmetic; flags = 0.
- **Handshake:**
  - A beat transfers when valid & ready.
  - `in_ready = !s1_valid | s1_adv`, where `s1_adv = !s2_valid | out_ready`.
  - All stage registers hold while stalled.
  - `out_*` is stable while `out_valid & !out_ready`.

## Timing
- Latency: 2 cycles from input handshake to `out_valid`, with no stall.
- Throughput: 1 beat per cycle.
- Reset values: `out_valid=0`, `out_result=0`, `out_flags=0`, all pipeline valids 0. `in_ready=1` from the first cycle after reset release.
- Asynchronous reset mid-operation discards all in-flight beats with no partial output.
- Simultaneous input accept and output drain in the same cycle is allowed; a full pipeline with `out_ready=1` keeps streaming.
- Outputs are registered; `in_ready` is combinational from `out_ready`.

## Configuration
- `FP_NR_FLAGS_EN` defined: the `out_flags` port and the flag pipeline registers exist.
- Undefined: port and registers absent; `out_result` behaviour identical.

## Structure
- Package `fp_single_pkg`:
  - Constants `EXP_BIAS=127`, `EXP_MAX=255`, `MANT_W=23`, `QNAN=32'h7FC00000`, `PINF=32'h7F800000`.
  - Typedef `fp32_t` packed struct `{sign, exp, frac}`.
  - Typedef `nr_flags_t`.
- Sub-module `lzc28`: combinational 28→5 leading-zero counter, instantiated in S1.
- S2 is inline in the top-level module.

## Test plan
- `in_exp=8'h80`, `in_mant=28'h1000000` (3.5−3.0) -> `out_result=32'h3F000000` two cycles later, flags 0.
- `in_exp=8'h7F`, `in_mant=28'hC000000` (carry) -> `32'h40400000`.
- Tie-to-even:
  - `in_exp=8'h7F`, `in_mant=28'h4000004` -> `32'h3F800000`, inexact=1.
  - `in_mant=28'h400000C` -> `32'h3F800002`.
- `in_exp=8'hFE`, `in_mant=28'hC000000` -> `32'h7F800000`, overflow=1. `in_mant=0` -> `32'h00000000`. `in_exp=1` with lzc=3 -> signed zero, underflow=1.
- Backpressure:
  - Issue 3 beats, hold `out_ready=0` for 4 cycles -> `in_ready` low after 2 accepted beats and `out_result` stable.
  - Release -> results emerge in order with none lost or duplicated.
- Assert `rst_n=0` with 2 beats in flight -> `out_valid=0` immediately. `in_special=1`, `in_special_val=32'h7FC00000` -> output 0x7FC00000, flags 0.

Source files
------------

// File: rtl/fp_single_pkg.sv
// Shared binary32 constants and payload types for the single-precision
// add/sub datapath.
package fp_single_pkg;

    localparam int unsigned EXP_BIAS  = 127;
    localparam int unsigned EXP_MAX   = 255;
    localparam int unsigned MANT_W    = 23;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned IEXP_W    = 10;   // signed working exponent
    localparam int unsigned RAW_W     = 28;   // carry + hidden + fraction + G/R/S
    localparam int unsigned NORM_W    = 27;   // hidden + fraction + G/R/S
    localparam int unsigned LZC_W     = 5;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } nr_flags_t;

    // Assemble a binary32 word from its fields.
    function automatic fp32_t pack_fp32(input logic sign,
                                        input logic [EXP_W-1:0] exp,
                                        input logic [MANT_W-1:0] frac);
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.frac = frac;
        return f;
    endfunction

endpackage

// File: rtl/lzc28.sv
// Combinational 28-bit leading-zero counter; returns 28 for an all-zero input.
module lzc28
    import fp_single_pkg::*;
(
    input  logic [RAW_W-1:0] value,
    output logic [LZC_W-1:0] count
);

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        count = LZC_W'(RAW_W);
        for (int i = 0; i < int'(RAW_W); i++) begin
            if (value[i]) begin
                count = LZC_W'(int'(RAW_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round_single.sv
// Post-add normalize / round-to-nearest-even / pack stage for binary32.
// Two-stage valid/ready pipeline: S1 normalizes, S2 rounds and packs.
// Optional macro FP_NR_FLAGS_EN adds the out_flags port and flag registers.
module fp_norm_round_single
    import fp_single_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [RAW_W-1:0]  in_mant,
    input  logic              in_special,
    input  logic [31:0]       in_special_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result
`ifdef FP_NR_FLAGS_EN
    ,
    output logic [2:0]        out_flags
`endif
);

    localparam logic signed [IEXP_W-1:0] EXP_OVF = IEXP_W'(EXP_MAX);
    localparam logic signed [IEXP_W-1:0] EXP_ONE = IEXP_W'(1);
    localparam logic signed [IEXP_W-1:0] EXP_ZERO = '0;

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_adv;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    // ---------------- S1: normalize ----------------
    logic [LZC_W-1:0]         lz;
    logic [LZC_W-1:0]         shamt;
    logic [NORM_W-1:0]        n_mant;
    logic signed [IEXP_W-1:0] n_exp;
    logic signed [IEXP_W-1:0] in_exp_s;

    logic                     s1_sign;
    logic signed [IEXP_W-1:0] s1_exp;
    logic [NORM_W-1:0]        s1_mant;
    logic                     s1_zero;
    logic                     s1_special;
    logic [31:0]              s1_special_val;

    lzc28 u_lzc (
        .value (in_mant),
        .count (lz)
    );

    assign in_exp_s = $signed({2'b00, in_exp});

    // Carry case folds the dropped bit into sticky; otherwise shift the hidden bit into place.
    always_comb begin
        n_mant = '0;
        n_exp  = in_exp_s;
        shamt  = '0;
        if (in_mant[RAW_W-1]) begin
            n_mant = {in_mant[RAW_W-1:2], in_mant[1] | in_mant[0]};
            n_exp  = in_exp_s + EXP_ONE;
        end else begin
            shamt  = lz - LZC_W'(1);
            n_mant = in_mant[NORM_W-1:0] << shamt;
            n_exp  = in_exp_s - $signed({{(IEXP_W-LZC_W){1'b0}}, shamt});
        end
    end

    // S1 register: loads on every accepted slot, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_exp         <= '0;
            s1_mant        <= '0;
            s1_zero        <= 1'b0;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign        <= in_sign;
                s1_exp         <= n_exp;
                s1_mant        <= n_mant;
                s1_zero        <= (in_mant == '0);
                s1_special     <= in_special;
                s1_special_val <= in_special_val;
            end
        end
    end

    // ---------------- S2: round and pack ----------------
    logic                     round_up;
    logic [MANT_W+1:0]        rsum;
    logic signed [IEXP_W-1:0] rexp;
    logic [MANT_W-1:0]        frac;
    logic                     is_ovf;
    logic                     is_unf;
    logic [31:0]              res;

    // Round-to-nearest-even on G/R/S, renormalize on carry-out, then range-check.
    always_comb begin
        round_up = s1_mant[2] & (s1_mant[1] | s1_mant[0] | s1_mant[3]);
        rsum     = {1'b0, s1_mant[NORM_W-1:3]} + (MANT_W+2)'(round_up);
        rexp     = s1_exp;
        frac     = rsum[MANT_W-1:0];
        if (rsum[MANT_W+1]) begin
            rexp = s1_exp + EXP_ONE;
            frac = rsum[MANT_W:1];
        end
        is_ovf = (rexp >= EXP_OVF);
        is_unf = (rexp <= EXP_ZERO);
        if (s1_special) begin
            res = s1_special_val;
        end else if (s1_zero) begin
            res = '0;
        end else if (is_ovf) begin
            res = PINF | {s1_sign, 31'd0};
        end else if (is_unf) begin
            res = {s1_sign, 31'd0};
        end else begin
            res = pack_fp32(s1_sign, EXP_W'(rexp), frac);
        end
    end

    // Output register: advances when the consumer is free, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res;
            end
        end
    end

`ifdef FP_NR_FLAGS_EN
    nr_flags_t flags_nx;

    // Exception flags; special and exact-zero beats report none.
    always_comb begin
        flags_nx = '0;
        if (!s1_special && !s1_zero) begin
            if (is_ovf) begin
                flags_nx.overflow = 1'b1;
                flags_nx.inexact  = 1'b1;
            end else if (is_unf) begin
                flags_nx.underflow = 1'b1;
                flags_nx.inexact   = 1'b1;
            end else begin
                flags_nx.inexact = |s1_mant[2:0];
            end
        end
    end

    // Flag register tracks the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= '0;
        end else if (s1_adv && s1_valid) begin
            out_flags <= flags_nx;
        end
    end
`endif

endmodule

// File: tb/tb_fp_norm_round_single.sv
// Self-checking bench for fp_norm_round_single: directed cases, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference.
module tb_fp_norm_round_single;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        special;
        logic [31:0] sval;
        logic [31:0] result;
        logic [2:0]  flags;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        in_special;
    logic [31:0] in_special_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FP_NR_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int total = 0;
    int bad   = 0;

    beat_t pend[$];
    beat_t sb[$];
    beat_t cur;
    bit    fired;
    bit    held_valid;
    logic [31:0] held_result;

    fp_norm_round_single dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result)
`ifdef FP_NR_FLAGS_EN
        ,
        .out_flags      (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: exact value m * 2^(e-153), rounded half-to-even to 24 significant bits.
    function automatic beat_t model(input logic s, input logic [7:0] e, input logic [27:0] m,
                                    input logic sp, input logic [31:0] sv);
        beat_t  b;
        int     p;
        int     ex;
        longint mm;
        longint sig;
        longint rem;
        longint half;
        b.sign = s; b.exp = e; b.mant = m; b.special = sp; b.sval = sv;
        b.result = '0;
        b.flags  = '0;
        if (sp) begin
            b.result = sv;
        end else if (m != 28'd0) begin
            mm = longint'(m);
            p  = 0;
            for (int i = 0; i < 28; i++) if (m[i]) p = i;
            ex = int'(e) + p - 26;
            if (p > 23) begin
                sig  = mm >> (p - 23);
                rem  = mm & ((64'sd1 << (p - 23)) - 64'sd1);
                half = 64'sd1 << (p - 24);
            end else begin
                sig  = mm << (23 - p);
                rem  = 0;
                half = 1;
            end
            if (rem > half || (rem == half && sig[0])) sig = sig + 1;
            if (sig == (64'sd1 << 24)) begin
                sig = sig >> 1;
                ex  = ex + 1;
            end
            if (ex >= 255) begin
                b.result = {s, 8'hFF, 23'd0};
                b.flags  = 3'b101;
            end else if (ex <= 0) begin
                b.result = {s, 31'd0};
                b.flags  = 3'b011;
            end else begin
                b.result = {s, 8'(ex), 23'(sig)};
                b.flags  = {2'b00, rem != 0};
            end
        end
        return b;
    endfunction

    function automatic beat_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                                 input logic sp, input logic [31:0] sv,
                                 input logic [31:0] res, input logic [2:0] fl);
        beat_t b;
        b.sign = s; b.exp = e; b.mant = m; b.special = sp; b.sval = sv;
        b.result = res;
        b.flags  = fl;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic        sp;
        logic [31:0] sv;
        int          k;
        s = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(1, 28));
            1:       e = 8'($urandom_range(228, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        k = $urandom_range(1, 28);
        m = 28'($urandom) & 28'((64'd1 << k) - 64'd1);
        if ($urandom_range(0, 1) == 1) m[k-1] = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
            m[27]  = 1'b0;
            m[26]  = 1'b1;
            m[2:0] = 3'b100;
        end
        if ($urandom_range(0, 31) == 0) m = '0;
        sp = ($urandom_range(0, 15) == 0);
        sv = $urandom;
        return model(s, e, m, sp, sv);
    endfunction

    // One cycle: settle, score the handshakes about to happen at the next edge, advance.
    task automatic tick();
        beat_t e;
        #1;
        if (sb.size() == 0) check_eq("idle_valid", 32'(out_valid), 32'd0);
        if (held_valid) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_result", out_result, held_result);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("result", out_result, e.result);
`ifdef FP_NR_FLAGS_EN
            check_eq("flags", 32'(out_flags), 32'(e.flags));
`endif
        end
        held_valid  = out_valid && !out_ready;
        held_result = out_result;
        fired = in_valid && in_ready;
        if (fired) sb.push_back(cur);
        @(negedge clk);
    endtask

    // rmode: 0 = consumer always ready, 1 = random ready and gaps, 2 = consumer stalled.
    task automatic step(input int rmode);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        if (pend.size() > 0 && (rmode != 1 || $urandom_range(0, 4) != 0)) begin
            cur            = pend[0];
            in_valid       = 1'b1;
            in_sign        = cur.sign;
            in_exp         = cur.exp;
            in_mant        = cur.mant;
            in_special     = cur.special;
            in_special_val = cur.sval;
        end else begin
            in_valid = 1'b0;
        end
        tick();
        if (fired) void'(pend.pop_front());
        in_valid = 1'b0;
    endtask

    task automatic run(input int max_cycles, input int rmode);
        for (int c = 0; c < max_cycles && (pend.size() > 0 || sb.size() > 0); c++) begin
            step(rmode);
        end
        check_eq("drain_timeout", 32'(pend.size() + sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_special = 1'b0; in_special_val = '0; out_ready = 1'b0;
        held_valid = 1'b0; held_result = '0; fired = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
`ifdef FP_NR_FLAGS_EN
        check_eq("rst_out_flags", 32'(out_flags), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed cases with hand-computed results.
        pend.push_back(mk(1'b0, 8'h80, 28'h1000000, 1'b0, 32'h0, 32'h3F000000, 3'b000));
        pend.push_back(mk(1'b0, 8'h7F, 28'hC000000, 1'b0, 32'h0, 32'h40400000, 3'b000));
        pend.push_back(mk(1'b0, 8'h7F, 28'h4000004, 1'b0, 32'h0, 32'h3F800000, 3'b001));
        pend.push_back(mk(1'b0, 8'h7F, 28'h400000C, 1'b0, 32'h0, 32'h3F800002, 3'b001));
        pend.push_back(mk(1'b0, 8'hFE, 28'hC000000, 1'b0, 32'h0, 32'h7F800000, 3'b101));
        pend.push_back(mk(1'b1, 8'h40, 28'h0000000, 1'b0, 32'h0, 32'h00000000, 3'b000));
        pend.push_back(mk(1'b1, 8'h01, 28'h0800000, 1'b0, 32'h0, 32'h80000000, 3'b011));
        pend.push_back(mk(1'b0, 8'h10, 28'h1234567, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000));
        run(100, 0);

        // Backpressure: three beats against a stalled consumer.
        for (int i = 0; i < 3; i++) pend.push_back(rnd_beat());
        repeat (4) step(2);
        check_eq("bp_accepted", 32'(3 - pend.size()), 32'd2);
        #1;
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        run(100, 0);

        // Reset with two beats in flight.
        pend.push_back(rnd_beat());
        pend.push_back(rnd_beat());
        step(2);
        step(2);
        check_eq("inflight", 32'(sb.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_result", out_result, 32'd0);
        sb.delete();
        pend.delete();
        held_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        repeat (4) step(0);

        // Randomized traffic with random stalls and input gaps.
        for (int i = 0; i < 400; i++) pend.push_back(rnd_beat());
        run(5000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
